// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for a 5-stage MIPS core.
// Tracks producer destination/Tnew through E, M and W, raises a D-stage stall
// when a consumer's Tuse is earlier than its producer's Tnew, and drives the
// forwarding selects for the D, E and M operand muxes.
// Optional stall cycle counter: define HAZARD_STALL_CNT_EN to build it;
// otherwise stall_count is tied to zero.
module hazard_ctrl #(
   parameter int unsigned TW = 2,
   parameter int unsigned AW = 5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [TW-1:0] Tuse_rs,
   input  logic [TW-1:0] Tuse_rt,
   input  logic [TW-1:0] TnewD,
   input  logic [AW-1:0] A_rsD,
   input  logic [AW-1:0] A_rtD,
   input  logic [AW-1:0] AwriteD,
   output logic          stall,
   output logic [1:0]    fwd_rsD,
   output logic [1:0]    fwd_rtD,
   output logic [1:0]    fwd_rsE,
   output logic [1:0]    fwd_rtE,
   output logic          fwd_rtM,
   output logic [31:0]   stall_count
);

   // Forward select encoding shared by the D and E muxes.
   localparam logic [1:0] FwdNone = 2'd0;
   localparam logic [1:0] FwdM    = 2'd1;
   localparam logic [1:0] FwdW    = 2'd2;

   // Saturating decrement of a Tnew value as it moves down the pipe.
   function automatic logic [TW-1:0] dec_t(input logic [TW-1:0] t);
      return (t == '0) ? '0 : t - TW'(1);
   endfunction

   // Register 0 is hard-wired, so it never creates a dependency.
   function automatic logic addr_hit(input logic [AW-1:0] a, input logic [AW-1:0] aw);
      return (a != '0) && (a == aw);
   endfunction

   // Younger producer (M) wins over the older one (W); only ready results forward.
   function automatic logic [1:0] fwd_sel(input logic [AW-1:0] a,
                                          input logic [AW-1:0] aw_m,
                                          input logic [TW-1:0] tnew_m,
                                          input logic [AW-1:0] aw_w,
                                          input logic [TW-1:0] tnew_w);
      logic [1:0] sel;
      sel = FwdNone;
      if (addr_hit(a, aw_m) && (tnew_m == '0)) begin
         sel = FwdM;
      end else if (addr_hit(a, aw_w) && (tnew_w == '0)) begin
         sel = FwdW;
      end
      return sel;
   endfunction

   // E-stage tracking
   logic [AW-1:0] a_rs_e_q, a_rs_e_d;
   logic [AW-1:0] a_rt_e_q, a_rt_e_d;
   logic [AW-1:0] aw_e_q,   aw_e_d;
   logic [TW-1:0] tnew_e_q, tnew_e_d;
   // M-stage tracking; rs is never consumed in M so it is not carried.
   logic [AW-1:0] a_rt_m_q, a_rt_m_d;
   logic [AW-1:0] aw_m_q,   aw_m_d;
   logic [TW-1:0] tnew_m_q, tnew_m_d;
   // W-stage tracking: producer info only.
   logic [AW-1:0] aw_w_q,   aw_w_d;
   logic [TW-1:0] tnew_w_q, tnew_w_d;

   // Individual stall causes, kept separate for readability in waveforms.
   logic stall_rs_e, stall_rs_m, stall_rt_e, stall_rt_m;

   // Stall when an operand is needed before its producer in E or M is ready.
   always_comb begin
      stall_rs_e = addr_hit(A_rsD, aw_e_q) && (Tuse_rs < tnew_e_q);
      stall_rs_m = addr_hit(A_rsD, aw_m_q) && (Tuse_rs < tnew_m_q);
      stall_rt_e = addr_hit(A_rtD, aw_e_q) && (Tuse_rt < tnew_e_q);
      stall_rt_m = addr_hit(A_rtD, aw_m_q) && (Tuse_rt < tnew_m_q);
      stall      = stall_rs_e | stall_rs_m | stall_rt_e | stall_rt_m;
   end

   // Forward selects, independent of stall; a held D stage re-evaluates next cycle.
   always_comb begin
      fwd_rsD = fwd_sel(A_rsD,    aw_m_q, tnew_m_q, aw_w_q, tnew_w_q);
      fwd_rtD = fwd_sel(A_rtD,    aw_m_q, tnew_m_q, aw_w_q, tnew_w_q);
      fwd_rsE = fwd_sel(a_rs_e_q, aw_m_q, tnew_m_q, aw_w_q, tnew_w_q);
      fwd_rtE = fwd_sel(a_rt_e_q, aw_m_q, tnew_m_q, aw_w_q, tnew_w_q);
      fwd_rtM = addr_hit(a_rt_m_q, aw_w_q) && (tnew_w_q == '0);
   end

   // Next tracking state: E takes D or a bubble on stall; M and W always advance.
   always_comb begin
      if (stall) begin
         a_rs_e_d = '0;
         a_rt_e_d = '0;
         aw_e_d   = '0;
         tnew_e_d = '0;
      end else begin
         a_rs_e_d = A_rsD;
         a_rt_e_d = A_rtD;
         aw_e_d   = AwriteD;
         tnew_e_d = dec_t(TnewD);
      end
      a_rt_m_d = a_rt_e_q;
      aw_m_d   = aw_e_q;
      tnew_m_d = dec_t(tnew_e_q);
      aw_w_d   = aw_m_q;
      tnew_w_d = dec_t(tnew_m_q);
   end

   // Tracking registers, cleared immediately on reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_rs_e_q <= '0;
         a_rt_e_q <= '0;
         aw_e_q   <= '0;
         tnew_e_q <= '0;
         a_rt_m_q <= '0;
         aw_m_q   <= '0;
         tnew_m_q <= '0;
         aw_w_q   <= '0;
         tnew_w_q <= '0;
      end else begin
         a_rs_e_q <= a_rs_e_d;
         a_rt_e_q <= a_rt_e_d;
         aw_e_q   <= aw_e_d;
         tnew_e_q <= tnew_e_d;
         a_rt_m_q <= a_rt_m_d;
         aw_m_q   <= aw_m_d;
         tnew_m_q <= tnew_m_d;
         aw_w_q   <= aw_w_d;
         tnew_w_q <= tnew_w_d;
      end
   end

`ifdef HAZARD_STALL_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   // Count stalled cycles; wraps naturally at 2^32.
   always_comb begin
      stall_cnt_d = stall ? stall_cnt_q + 32'd1 : stall_cnt_q;
   end

   // Stall counter register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_count = stall_cnt_q;
`else
   assign stall_count = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: table of D-stage instructions with the
// expected stall/forward outputs, checked through an expectation queue, plus
// a reset-during-stall sequence and stall counter checks.
module tb_hazard_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  Tuse_rs, Tuse_rt, TnewD;
   logic [4:0]  A_rsD, A_rtD, AwriteD;
   logic        stall;
   logic [1:0]  fwd_rsD, fwd_rtD, fwd_rsE, fwd_rtE;
   logic        fwd_rtM;
   logic [31:0] stall_count;

   int checks = 0;
   int errors = 0;

   hazard_ctrl #(.TW(2), .AW(5)) dut (
      .clk         (clk),
      .reset       (reset),
      .Tuse_rs     (Tuse_rs),
      .Tuse_rt     (Tuse_rt),
      .TnewD       (TnewD),
      .A_rsD       (A_rsD),
      .A_rtD       (A_rtD),
      .AwriteD     (AwriteD),
      .stall       (stall),
      .fwd_rsD     (fwd_rsD),
      .fwd_rtD     (fwd_rtD),
      .fwd_rsE     (fwd_rsE),
      .fwd_rtE     (fwd_rtE),
      .fwd_rtM     (fwd_rtM),
      .stall_count (stall_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] tuse_rs, tuse_rt, tnew;
      logic [4:0] a_rs, a_rt, aw;
      logic       stall;
      logic [1:0] rsd, rtd, rse, rte;
      logic       rtm;
   } vec_t;

   typedef struct {
      logic       stall;
      logic [1:0] rsd, rtd, rse, rte;
      logic       rtm;
   } exp_t;

   exp_t exp_q[$];
   vec_t vecs[28];

   function automatic vec_t mk(input int tuse_rs, input int tuse_rt, input int tnew,
                               input int rs, input int rt, input int aw,
                               input int st, input int rsd, input int rtd,
                               input int rse, input int rte, input int rtm);
      vec_t v;
      v.tuse_rs = 2'(tuse_rs); v.tuse_rt = 2'(tuse_rt); v.tnew = 2'(tnew);
      v.a_rs = 5'(rs); v.a_rt = 5'(rt); v.aw = 5'(aw);
      v.stall = 1'(st); v.rsd = 2'(rsd); v.rtd = 2'(rtd);
      v.rse = 2'(rse); v.rte = 2'(rte); v.rtm = 1'(rtm);
      return v;
   endfunction

   task automatic chk(input string name, input string field,
                      input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s.%s: got %0d expected %0d", name, field, act, req);
      end
   endtask

   // Drive D inputs and queue the outputs they should produce.
   task automatic apply(input vec_t v);
      exp_t e;
      Tuse_rs = v.tuse_rs; Tuse_rt = v.tuse_rt; TnewD = v.tnew;
      A_rsD = v.a_rs; A_rtD = v.a_rt; AwriteD = v.aw;
      e.stall = v.stall; e.rsd = v.rsd; e.rtd = v.rtd;
      e.rse = v.rse; e.rte = v.rte; e.rtm = v.rtm;
      exp_q.push_back(e);
   endtask

   // Pop the oldest expectation and compare against the DUT outputs.
   task automatic compare(input string name);
      exp_t e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: no expectation queued", name);
         return;
      end
      e = exp_q.pop_front();
      chk(name, "stall",   32'(stall),   32'(e.stall));
      chk(name, "fwd_rsD", 32'(fwd_rsD), 32'(e.rsd));
      chk(name, "fwd_rtD", 32'(fwd_rtD), 32'(e.rtd));
      chk(name, "fwd_rsE", 32'(fwd_rsE), 32'(e.rse));
      chk(name, "fwd_rtE", 32'(fwd_rtE), 32'(e.rte));
      chk(name, "fwd_rtM", 32'(fwd_rtM), 32'(e.rtm));
   endtask

   task automatic step(input vec_t v, input string name);
      @(posedge clk);
      #1;
      apply(v);
      @(negedge clk);
      compare(name);
   endtask

   initial begin
      vec_t nop, lw5, use5;
      logic [31:0] exp_cnt;
      nop  = mk(3, 3, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
      lw5  = mk(1, 3, 3, 29, 0, 5, 0, 0, 0, 0, 0, 0);
      use5 = mk(1, 1, 2, 5, 7, 8,  1, 0, 0, 0, 0, 0);
`ifdef HAZARD_STALL_CNT_EN
      exp_cnt = 32'd3;
`else
      exp_cnt = 32'd0;
`endif

      // addu $3 then beq on $3: one stall, then forward from M
      vecs[0]  = mk(1, 1, 2, 1, 2, 3,    0, 0, 0, 0, 0, 0);
      vecs[1]  = mk(0, 3, 0, 3, 0, 0,    1, 0, 0, 0, 0, 0);
      vecs[2]  = mk(0, 3, 0, 3, 0, 0,    0, 1, 0, 0, 0, 0);
      vecs[3]  = mk(3, 3, 0, 0, 0, 0,    0, 0, 0, 2, 0, 0);
      vecs[4]  = nop;
      // lw $5 then addu on $5: one stall, then E forward from W
      vecs[5]  = lw5;
      vecs[6]  = use5;
      vecs[7]  = mk(1, 1, 2, 5, 7, 8,    0, 0, 0, 0, 0, 0);
      vecs[8]  = mk(3, 3, 0, 0, 0, 0,    0, 0, 0, 2, 0, 0);
      vecs[9]  = nop;
      // addu $4, unrelated ori, sw rt=$4: no stall
      vecs[10] = mk(1, 1, 2, 1, 2, 4,    0, 0, 0, 0, 0, 0);
      vecs[11] = mk(1, 3, 2, 10, 0, 9,   0, 0, 0, 0, 0, 0);
      vecs[12] = mk(1, 2, 0, 29, 4, 0,   0, 0, 1, 0, 0, 0);
      vecs[13] = mk(3, 3, 0, 0, 0, 0,    0, 0, 0, 0, 2, 0);
      vecs[14] = nop;
      // lw $6 then sw rt=$6: Tuse 2 is not < 2, store data from W in M
      vecs[15] = mk(1, 3, 3, 29, 0, 6,   0, 0, 0, 0, 0, 0);
      vecs[16] = mk(1, 2, 0, 29, 6, 0,   0, 0, 0, 0, 0, 0);
      vecs[17] = nop;
      vecs[18] = mk(3, 3, 0, 0, 0, 0,    0, 0, 0, 0, 0, 1);
      vecs[19] = nop;
      // register 0 never stalls or forwards
      vecs[20] = mk(0, 0, 2, 0, 0, 0,    0, 0, 0, 0, 0, 0);
      vecs[21] = mk(0, 0, 2, 0, 0, 0,    0, 0, 0, 0, 0, 0);
      vecs[22] = mk(0, 0, 2, 0, 0, 0,    0, 0, 0, 0, 0, 0);
      // $11 written twice: E stalls, M beats W on forwarding
      vecs[23] = mk(1, 1, 2, 1, 2, 11,   0, 0, 0, 0, 0, 0);
      vecs[24] = mk(1, 1, 2, 1, 2, 11,   0, 0, 0, 0, 0, 0);
      vecs[25] = mk(0, 3, 0, 11, 0, 0,   1, 1, 0, 0, 0, 0);
      vecs[26] = mk(0, 3, 0, 11, 0, 0,   0, 1, 0, 0, 0, 0);
      vecs[27] = mk(3, 3, 0, 0, 0, 0,    0, 0, 0, 2, 0, 0);

      // Reset state with busy-looking D inputs
      reset = 1'b1;
      apply(mk(0, 0, 3, 7, 7, 7, 0, 0, 0, 0, 0, 0));
      #2;
      compare("reset");
      chk("reset", "stall_count", stall_count, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 28; i++) begin
         step(vecs[i], $sformatf("vec%0d", i));
      end
      chk("table", "stall_count", stall_count, exp_cnt);

      // Reset asserted while stalled clears everything immediately
      step(lw5, "mid_lw");
      step(use5, "mid_use");
      #1;
      reset = 1'b1;
      apply(nop);
      #1;
      compare("mid_reset");
      chk("mid_reset", "stall_count", stall_count, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Three lw/use stalls after reset
      for (int k = 0; k < 3; k++) begin
         step(lw5, $sformatf("post_lw%0d", k));
         step(use5, $sformatf("post_use%0d", k));
         step(mk(1, 1, 2, 5, 7, 8, 0, 0, 0, 0, 0, 0), $sformatf("post_held%0d", k));
         step(mk(3, 3, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0), $sformatf("post_nop%0d", k));
      end
      chk("post_reset", "stall_count", stall_count, exp_cnt);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
